uart_tx_cfg: RTL and testbench

Parametrised, runtime-configurable UART transmitter, successor to the fixed 8N1 transmitter. Supports DATA_BITS of 5 to 9, runtime none/even/odd parity and 1 or 2 stop bits. A valid/ready input with a one-word holding register allows back-to-back frames with zero idle time. Sits between the host-side byte stream and the pad; bit timing comes from the shared external baud_tick generator.

---
 rtl/uart_pkg.sv | 37 +++
 rtl/uart_tx_cfg_if.sv | 22 ++
 rtl/uart_tx_cfg.sv | 133 +++++++++++++
 tb/tb_uart_tx_cfg.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART transmitter:
// FSM state encoding, parity-mode codes and the parity calculation.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   localparam int MAX_DATA_BITS = 9;

   // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
   function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                       input logic [1:0] mode);
      logic even_par;
      even_par = ^data;
      return (mode == PAR_ODD) ? ~even_par : even_par;
   endfunction

   function automatic logic parity_enabled(input logic [1:0] mode);
      logic en;
      case (mode)
         PAR_EVEN, PAR_ODD: en = 1'b1;
         PAR_NONE:          en = 1'b0;
         default:           en = 1'b0;
      endcase
      return en;
   endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Host-side valid/ready word stream feeding the UART transmitter.
interface uart_tx_cfg_if #(
   parameter int DATA_BITS = 8
);

   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_valid;
   logic                 tx_ready;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready
   );

endinterface

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter (5..9 data bits, none/even/odd parity,
// 1 or 2 stop bits) with a one-word holding register for back-to-back frames.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               baud_tick,
   uart_tx_cfg_if.slave       tx_if,
   input  logic [1:0]         cfg_parity,
   input  logic               cfg_stop2,
   output logic               uart_tx_out,
   output logic               tx_busy,
   output logic               frame_done
);

   localparam logic [3:0] LAST_BIT = 4'(DATA_BITS);

   tx_state_t              state;
   logic                   hold_full;
   logic [DATA_BITS-1:0]   hold_data;
   logic [DATA_BITS-1:0]   shift_reg;
   logic [MAX_DATA_BITS-1:0] hold_wide;
   logic [3:0]             bit_cnt;
   logic                   stop_cnt;
   logic                   frame_par_en;
   logic                   frame_par_bit;
   logic                   frame_stop2;
   logic                   accept;
   logic                   stop_last;
   logic                   load;

   // Zero-extend the held word so the package parity helper works for any width.
   always_comb begin
      hold_wide                  = '0;
      hold_wide[DATA_BITS-1:0]   = hold_data;
   end

   assign tx_if.tx_ready = !hold_full;
   assign tx_busy        = (state != IDLE);
   assign accept         = tx_if.tx_valid && !hold_full;
   assign stop_last      = !(frame_stop2 && !stop_cnt);
   assign load           = baud_tick && hold_full &&
                           ((state == IDLE) || ((state == STOP) && stop_last));

   // Holding register: accept only while empty, so accept and load never collide.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_full <= 1'b0;
         hold_data <= '0;
      end else if (load) begin
         hold_full <= 1'b0;
      end else if (accept) begin
         hold_full <= 1'b1;
         hold_data <= tx_if.tx_data;
      end
   end

   // Bit sequencer: every line change happens on a baud tick; the load block at
   // the end overrides the case so a held word starts with no idle gap.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         uart_tx_out   <= 1'b1;
         frame_done    <= 1'b0;
         shift_reg     <= '0;
         bit_cnt       <= '0;
         stop_cnt      <= 1'b0;
         frame_par_en  <= 1'b0;
         frame_par_bit <= 1'b0;
         frame_stop2   <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (baud_tick) begin
            case (state)
               IDLE: begin
                  uart_tx_out <= 1'b1;
               end
               START: begin
                  uart_tx_out <= shift_reg[0];
                  shift_reg   <= shift_reg >> 1;
                  bit_cnt     <= 4'd1;
                  state       <= DATA;
               end
               DATA: begin
                  if (bit_cnt < LAST_BIT) begin
                     uart_tx_out <= shift_reg[0];
                     shift_reg   <= shift_reg >> 1;
                     bit_cnt     <= bit_cnt + 4'd1;
                  end else if (frame_par_en) begin
                     uart_tx_out <= frame_par_bit;
                     state       <= PARITY;
                  end else begin
                     uart_tx_out <= 1'b1;
                     stop_cnt    <= 1'b0;
                     state       <= STOP;
                  end
               end
               PARITY: begin
                  uart_tx_out <= 1'b1;
                  stop_cnt    <= 1'b0;
                  state       <= STOP;
               end
               STOP: begin
                  if (!stop_last) begin
                     stop_cnt <= 1'b1;
                  end else begin
                     frame_done  <= 1'b1;
                     uart_tx_out <= 1'b1;
                     state       <= IDLE;
                  end
               end
               default: begin
                  uart_tx_out <= 1'b1;
                  state       <= IDLE;
               end
            endcase

            if (load) begin
               shift_reg     <= hold_data;
               frame_par_en  <= parity_enabled(cfg_parity);
               frame_par_bit <= parity_bit(hold_wide, cfg_parity);
               frame_stop2   <= cfg_stop2;
               uart_tx_out   <= 1'b0;
               state         <= START;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed self-checking bench for uart_tx_cfg: an 8-bit and a 7-bit instance
// share clock, reset, baud tick and config; each frame is checked bit by bit.
module tb_uart_tx_cfg;

   logic       clk;
   logic       rst;
   logic       baud_tick;
   logic [1:0] cfg_parity;
   logic       cfg_stop2;
   logic       line8, busy8, done8;
   logic       line7, busy7, done7;
   logic       cur;
   logic       obs_line, obs_busy, obs_done, obs_ready;
   int         checks;
   int         errors;

   uart_tx_cfg_if #(.DATA_BITS(8)) if8 ();
   uart_tx_cfg_if #(.DATA_BITS(7)) if7 ();

   uart_tx_cfg #(.DATA_BITS(8)) dut8 (
      .clk         (clk),
      .rst         (rst),
      .baud_tick   (baud_tick),
      .tx_if       (if8.slave),
      .cfg_parity  (cfg_parity),
      .cfg_stop2   (cfg_stop2),
      .uart_tx_out (line8),
      .tx_busy     (busy8),
      .frame_done  (done8)
   );

   uart_tx_cfg #(.DATA_BITS(7)) dut7 (
      .clk         (clk),
      .rst         (rst),
      .baud_tick   (baud_tick),
      .tx_if       (if7.slave),
      .cfg_parity  (cfg_parity),
      .cfg_stop2   (cfg_stop2),
      .uart_tx_out (line7),
      .tx_busy     (busy7),
      .frame_done  (done7)
   );

   assign obs_line  = cur ? line7 : line8;
   assign obs_busy  = cur ? busy7 : busy8;
   assign obs_done  = cur ? done7 : done8;
   assign obs_ready = cur ? if7.tx_ready : if8.tx_ready;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Present one word on the selected instance and confirm it was taken.
   task automatic applyStimulus(input logic sel, input logic [8:0] word);
      @(negedge clk);
      cur = sel;
      if (sel) begin
         if7.tx_data  = word[6:0];
         if7.tx_valid = 1'b1;
      end else begin
         if8.tx_data  = word[7:0];
         if8.tx_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      checkOutput("ready_drop", obs_ready, 1'b0);
      @(negedge clk);
      if7.tx_valid = 1'b0;
      if8.tx_valid = 1'b0;
   endtask

   // n clocks per bit, tick on the last one; returns 1 time unit after that edge.
   task automatic baudPeriod(input int n);
      for (int k = 0; k < n - 1; k++) @(negedge clk);
      @(negedge clk);
      baud_tick = 1'b1;
      @(posedge clk);
      #1;
      baud_tick = 1'b0;
   endtask

   task automatic runBits(input string tag, input logic [11:0] bits,
                          input int from, input int upto);
      for (int i = from; i <= upto; i++) begin
         baudPeriod(16);
         checkOutput($sformatf("%s line bit%0d", tag, i), obs_line, bits[i]);
         checkOutput($sformatf("%s busy bit%0d", tag, i), obs_busy, 1'b1);
         checkOutput($sformatf("%s done bit%0d", tag, i), obs_done, 1'b0);
      end
   endtask

   task automatic endFrame(input string tag, input logic exp_line,
                           input logic exp_busy, input logic exp_ready);
      baudPeriod(16);
      checkOutput({tag, " done pulse"}, obs_done, 1'b1);
      checkOutput({tag, " end line"}, obs_line, exp_line);
      checkOutput({tag, " end busy"}, obs_busy, exp_busy);
      checkOutput({tag, " end ready"}, obs_ready, exp_ready);
      @(posedge clk);
      #1;
      checkOutput({tag, " done clears"}, obs_done, 1'b0);
   endtask

   task automatic idleTicks(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         baudPeriod(16);
         checkOutput($sformatf("%s idle line %0d", tag, i), obs_line, 1'b1);
         checkOutput($sformatf("%s idle busy %0d", tag, i), obs_busy, 1'b0);
         checkOutput($sformatf("%s idle done %0d", tag, i), obs_done, 1'b0);
      end
   endtask

   // Frame vectors are written {stop(s), parity, data MSB..LSB, start}; bit 0 goes first.
   initial begin
      checks       = 0;
      errors       = 0;
      cur          = 1'b0;
      rst          = 1'b1;
      baud_tick    = 1'b0;
      cfg_parity   = 2'b00;
      cfg_stop2    = 1'b0;
      if8.tx_data  = '0;
      if8.tx_valid = 1'b0;
      if7.tx_data  = '0;
      if7.tx_valid = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst line8", line8, 1'b1);
      checkOutput("rst ready8", if8.tx_ready, 1'b1);
      checkOutput("rst busy8", busy8, 1'b0);
      checkOutput("rst done8", done8, 1'b0);
      checkOutput("rst line7", line7, 1'b1);
      checkOutput("rst ready7", if7.tx_ready, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      $display("[TB] reset released");

      // 8N1 0x55; config is scribbled after the start bit and must be ignored.
      applyStimulus(1'b0, 9'h055);
      runBits("8N1", 12'b00_1_01010101_0, 0, 0);
      cfg_parity = 2'b01;
      cfg_stop2  = 1'b1;
      runBits("8N1", 12'b00_1_01010101_0, 1, 9);
      endFrame("8N1", 1'b1, 1'b0, 1'b1);

      cfg_parity = 2'b01;
      cfg_stop2  = 1'b0;
      applyStimulus(1'b0, 9'h0A3);
      runBits("8E1", 12'b0_1_0_10100011_0, 0, 10);
      endFrame("8E1", 1'b1, 1'b0, 1'b1);

      cfg_parity = 2'b10;
      applyStimulus(1'b0, 9'h0A3);
      runBits("8O1", 12'b0_1_1_10100011_0, 0, 10);
      endFrame("8O1", 1'b1, 1'b0, 1'b1);

      cfg_parity = 2'b11;
      applyStimulus(1'b0, 9'h0A3);
      runBits("8P11", 12'b00_1_10100011_0, 0, 9);
      endFrame("8P11", 1'b1, 1'b0, 1'b1);

      cfg_parity = 2'b00;
      cfg_stop2  = 1'b1;
      applyStimulus(1'b0, 9'h000);
      runBits("8N2", 12'b0_11_00000000_0, 0, 10);
      endFrame("8N2", 1'b1, 1'b0, 1'b1);

      // Back-to-back: second word accepted right after the first loads.
      cfg_stop2 = 1'b0;
      applyStimulus(1'b0, 9'h001);
      runBits("b2b A", 12'b00_1_00000001_0, 0, 0);
      checkOutput("b2b ready after load", obs_ready, 1'b1);
      applyStimulus(1'b0, 9'h080);
      runBits("b2b A", 12'b00_1_00000001_0, 1, 9);
      endFrame("b2b A", 1'b0, 1'b1, 1'b1);
      runBits("b2b B", 12'b00_1_10000000_0, 1, 9);
      endFrame("b2b B", 1'b1, 1'b0, 1'b1);

      // 7-bit instance, even parity over seven ones.
      cfg_parity = 2'b01;
      applyStimulus(1'b1, 9'h07F);
      runBits("7E1", 12'b00_1_1_1111111_0, 0, 9);
      endFrame("7E1", 1'b1, 1'b0, 1'b1);

      // Reset during data bit 3 with a second word held.
      cur        = 1'b0;
      cfg_parity = 2'b00;
      applyStimulus(1'b0, 9'h000);
      runBits("rstmid", 12'b00_1_00000000_0, 0, 4);
      applyStimulus(1'b0, 9'h05A);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("rstmid line", obs_line, 1'b1);
      checkOutput("rstmid ready", obs_ready, 1'b1);
      checkOutput("rstmid busy", obs_busy, 1'b0);
      checkOutput("rstmid done", obs_done, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      idleTicks("rstmid", 12);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
